data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Byte-serial data-memory controller serving the MEM stage's load/store requests: the write-capable counterpart to the byte-addressed, big-endian instruction memory.
- Holds a 512 x 8 byte array and accepts one request at a time over a valid/ready handshake.
- Moves one byte per cycle and returns loaded data zero- or sign-extended per MEM_SE.
- Sits between the MEM pipeline register (MEM_RW, MEM_Size, MEM_SE, MEM_Enable) and the WB mux.

Parameters:
ADDR_WIDTH, 9, byte-address width
DEPTH, 512, number of byte locations (2**ADDR_WIDTH)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
req_valid  input  1  request present (driven by MEM_Enable)
req_ready  output  1  controller can accept a request
req_rw  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_se  input  1  1 = sign-extend load, 0 = zero-extend
req_addr  input  ADDR_WIDTH  byte address of the most-significant byte
req_wdata  input  32  store data, right-justified
resp_valid  output  1  access complete, result valid
resp_ready  input  1  consumer accepts the response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or reserved-size request
busy  output  1  high in any state except IDLE

Behaviour:
- The clock is clk; reset is synchronous and active-low.
- Reset (reset==0 at posedge):
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - Byte counter and assembly register are cleared.
  - Memory array contents are NOT reset.
- FSM states are IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a posedge, latch rw, size, se, addr, wdata and set n = 1/2/4 bytes for size 00/01/10.
  - Misaligned request (size 01 with addr[0]=1, size 10 with addr[1:0]!=0) or size 11: go straight to RESP with resp_err=1 and resp_rdata=0. No memory access.
  - Otherwise go to ACCESS with byte index i=0.
- ACCESS:
  - req_ready=0. Exactly one byte is transferred per cycle, at address addr+i.
  - Big-endian: i=0 is the most-significant byte of the access.
  - Store: write byte (n-1-i) of req_wdata. Word writes [31:24],[23:16],[15:8],[7:0]; halfword writes [15:8],[7:0]; byte writes [7:0].
  - Load: shift the byte into the assembly register, acc = {acc[23:0], Mem[addr+i]}.
  - After byte i=n-1, go to RESP.
- RESP:
  - resp_valid=1. Held stable until resp_ready=1 at a posedge, then go to IDLE.
  - Load: resp_rdata = acc extended from 8 or 16 bits. Sign-extend when se=1, zero-extend when se=0. Word loads ignore se.
  - Store: resp_rdata=0.
  - resp_err=0 except on an error response.
- Latency:
  - Handshake at edge T; the final byte moves at edge T+n; resp_valid goes high after edge T+n.
  - With resp_ready tied 1, the next request is accepted at edge T+n+2.
  - Error responses go high after edge T.
- Ignored inputs:
  - req_valid outside IDLE is ignored; the request is not queued.
  - Input changes after the handshake do not affect the access in flight.
- Addressing: aligned accesses never cross DEPTH-1, so there is no wrap-around. Address arithmetic is ADDR_WIDTH bits wide.
- Reset mid-ACCESS:
  - Bytes already written stay written; remaining bytes are not written.
  - No response is issued.
- Reset during RESP drops the pending response.
- Store-then-load to the same address returns the stored data; the store has completed before the load is accepted.

Test Plan:
- Word store addr=0x010, wdata=0xDEADBEEF, then word load addr=0x010 -> Mem[0x10..0x13]=DE,AD,BE,EF; load rdata=0xDEADBEEF; resp_valid 5 cycles after handshake with resp_ready=1.
- Byte store 0x80 to addr=0x021, then load byte with se=1 -> rdata=0xFFFFFF80; load with se=0 -> rdata=0x00000080.
- Halfword store 0x8001 to addr=0x030, then halfword load with se=1 -> rdata=0xFFFF8001; Mem[0x31]=0x01; resp_valid 3 cycles after handshake.
- Halfword load addr=0x033, then word store addr=0x042 -> each gives an immediate error response: resp_err=1, rdata=0, memory unchanged, busy clears next cycle.
- Word store 0x11223344 to addr=0x100; assert reset after 2 ACCESS cycles -> resp_valid never rises; Mem[0x100]=0x11, Mem[0x101]=0x22, Mem[0x102..0x103] unchanged; req_ready=1 after reset.
- resp_ready held 0 for 3 cycles in RESP -> resp_valid/resp_rdata stable; req_valid pulses during ACCESS and RESP are ignored; the next request is accepted only in IDLE.

Source files
------------

// File: rtl/data_mem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_if : request/response bundle for the byte-serial data memory   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface data_mem_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [1:0]            req_size;
    logic                  req_se;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  busy;

    modport master (
        output req_valid, req_rw, req_size, req_se, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_rw, req_size, req_se, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_ctrl : big-endian byte-serial load/store controller, 512 x 8    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];

    logic                  rw;
    logic                  se;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [1:0]            last;
    logic [1:0]            idx;
    logic [31:0]           acc;

    logic                  ready_q;
    logic                  valid_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  busy_q;

    logic [ADDR_WIDTH-1:0] byte_addr;
    logic [7:0]            rd_byte;
    logic [7:0]            wr_byte;
    logic [1:0]            sel;
    logic [31:0]           acc_next;
    logic                  mem_we;
    logic                  req_bad;
    logic [1:0]            req_last;

    function automatic logic [31:0] extend(input logic [1:0] sz, input logic sx,
                                           input logic [31:0] v);
        case (sz)
            2'b00:   return sx ? {{24{v[7]}}, v[7:0]}   : {24'h0, v[7:0]};
            2'b01:   return sx ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign byte_addr = addr + ADDR_WIDTH'(idx);
    assign rd_byte   = mem[byte_addr];
    assign acc_next  = {acc[23:0], rd_byte};
    // Byte i of an n-byte store is wdata byte (n-1-i): MSB goes to the lowest address.
    assign sel       = last - idx;
    assign mem_we    = reset && (state == ACCESS) && rw;

    always_comb begin
        wr_byte = wdata[7:0];
        case (sel)
            2'd0:    wr_byte = wdata[7:0];
            2'd1:    wr_byte = wdata[15:8];
            2'd2:    wr_byte = wdata[23:16];
            default: wr_byte = wdata[31:24];
        endcase
    end

    always_comb begin
        req_bad  = 1'b0;
        req_last = 2'd0;
        case (bus.req_size)
            2'b00: begin req_bad = 1'b0;                 req_last = 2'd0; end
            2'b01: begin req_bad = bus.req_addr[0];      req_last = 2'd1; end
            2'b10: begin req_bad = |bus.req_addr[1:0];   req_last = 2'd3; end
            default: begin req_bad = 1'b1;               req_last = 2'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[byte_addr] <= wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            idx     <= 2'd0;
            acc     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rw      <= bus.req_rw;
                        size    <= bus.req_size;
                        se      <= bus.req_se;
                        addr    <= bus.req_addr;
                        wdata   <= bus.req_wdata;
                        last    <= req_last;
                        idx     <= 2'd0;
                        acc     <= 32'h0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (req_bad) begin
                            state   <= RESP;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    acc <= acc_next;
                    idx <= idx + 2'd1;
                    if (idx == last) begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= rw ? 32'h0 : extend(size, se, acc_next);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        rdata_q <= 32'h0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = busy_q;
endmodule
`default_nettype wire
